// File: rtl/window_conv_pkg.sv
// Shared defaults, datapath width helpers and kernel constants for the windowed convolution block.
package window_conv_pkg;

    localparam int unsigned DEF_PX_WIDTH    = 12;
    localparam int unsigned DEF_PX_PER_CLK  = 4;
    localparam int unsigned DEF_WIN_SIZE    = 3;
    localparam int unsigned DEF_COEF_WIDTH  = 8;
    localparam int unsigned SHIFT_WIDTH     = 4;
    localparam int unsigned SIDEBAND_WIDTH  = 4;
    localparam int unsigned LATENCY         = 4;
    localparam int unsigned KERNEL_MAX_BITS = 1024;

    typedef struct packed {
        logic frame_start;
        logic frame_end;
        logic line_start;
        logic line_end;
    } sideband_t;

    // Zero-extended pixel times signed coefficient.
    function automatic int unsigned prod_width(int unsigned px_w, int unsigned coef_w);
        return px_w + coef_w + 1;
    endfunction

    // Sum of all taps; the extra bits make overflow impossible.
    function automatic int unsigned sum_width(int unsigned px_w, int unsigned coef_w, int unsigned win);
        return prod_width(px_w, coef_w) + $clog2(win * win);
    endfunction

    // Identity kernel: centre tap 1, all others 0; caller slices to its own width.
    function automatic logic [KERNEL_MAX_BITS-1:0] kernel_ident(int unsigned win, int unsigned coef_w);
        return KERNEL_MAX_BITS'(1) << (((win / 2) * win + (win / 2)) * coef_w);
    endfunction

    localparam int unsigned DEF_KERNEL_BITS = DEF_WIN_SIZE * DEF_WIN_SIZE * DEF_COEF_WIDTH;
    localparam logic [DEF_KERNEL_BITS-1:0] IDENT_KERNEL =
        DEF_KERNEL_BITS'(kernel_ident(DEF_WIN_SIZE, DEF_COEF_WIDTH));

endpackage

// File: rtl/window_conv_if.sv
// Pixel stream in (per-lane windows + sideband) and filtered stream out.
interface window_conv_if #(
    parameter int unsigned PX_WIDTH   = 12,
    parameter int unsigned PX_PER_CLK = 4,
    parameter int unsigned WIN_SIZE   = 3
);
    localparam int unsigned WIN_BITS = PX_PER_CLK * WIN_SIZE * WIN_SIZE * PX_WIDTH;
    localparam int unsigned OUT_BITS = PX_PER_CLK * PX_WIDTH;

    logic [WIN_BITS-1:0]   win_data_i;
    logic [PX_PER_CLK-1:0] win_data_val_i;
    logic                  frame_start_i;
    logic                  frame_end_i;
    logic                  line_start_i;
    logic                  line_end_i;

    logic [OUT_BITS-1:0]   px_data_o;
    logic [PX_PER_CLK-1:0] px_data_val_o;
    logic                  frame_start_o;
    logic                  frame_end_o;
    logic                  line_start_o;
    logic                  line_end_o;

    modport master (
        output win_data_i, win_data_val_i, frame_start_i, frame_end_i, line_start_i, line_end_i,
        input  px_data_o, px_data_val_o, frame_start_o, frame_end_o, line_start_o, line_end_o
    );

    modport slave (
        input  win_data_i, win_data_val_i, frame_start_i, frame_end_i, line_start_i, line_end_i,
        output px_data_o, px_data_val_o, frame_start_o, frame_end_o, line_start_o, line_end_o
    );
endinterface

// File: rtl/stream_delay.sv
// Fixed-depth shift register used to align valid and sideband with the datapath.
module stream_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/window_conv.sv
// Per-lane WIN_SIZE x WIN_SIZE convolution with rounding, normalising shift and saturation;
// kernel updates are shadowed and only applied between frames or on a frame-start beat.
module window_conv
    import window_conv_pkg::*;
#(
    parameter int unsigned PX_WIDTH   = DEF_PX_WIDTH,
    parameter int unsigned PX_PER_CLK = DEF_PX_PER_CLK,
    parameter int unsigned WIN_SIZE   = DEF_WIN_SIZE,
    parameter int unsigned COEF_WIDTH = DEF_COEF_WIDTH
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    window_conv_if.slave                           bus,
    input  logic [WIN_SIZE*WIN_SIZE*COEF_WIDTH-1:0] coef_i,
    input  logic [SHIFT_WIDTH-1:0]                 norm_shift_i,
    input  logic                                   cfg_wr_i,
    output logic                                   cfg_pending_o
);

    localparam int unsigned NTAP = WIN_SIZE * WIN_SIZE;
    localparam int unsigned PW   = prod_width(PX_WIDTH, COEF_WIDTH);
    localparam int unsigned SW   = sum_width(PX_WIDTH, COEF_WIDTH, WIN_SIZE);
    localparam int unsigned TW   = SW + 1;
    localparam int unsigned KW   = NTAP * COEF_WIDTH;
    localparam int unsigned DW   = SIDEBAND_WIDTH + PX_PER_CLK;
    localparam logic [KW-1:0] IDENT = KW'(kernel_ident(WIN_SIZE, COEF_WIDTH));

    logic [KW-1:0]          act_coef_q, shd_coef_q, kern_c;
    logic [SHIFT_WIDTH-1:0] act_shift_q, shd_shift_q, shift_c;
    logic [SHIFT_WIDTH-1:0] sh1_q, sh2_q, sh3_q;
    logic                   pending_q, in_frame_q;
    logic                   any_val, fs_beat, fe_beat, use_shadow, promote;
    logic signed [TW-1:0]   round_c;

    assign any_val    = |bus.win_data_val_i;
    assign fs_beat    = bus.frame_start_i & any_val;
    assign fe_beat    = bus.frame_end_i & any_val;
    assign use_shadow = pending_q & fs_beat;
    // Outside a frame, or at the start of a new one, a pending kernel becomes active.
    assign promote    = pending_q & (fs_beat | ~in_frame_q);
    assign kern_c     = use_shadow ? shd_coef_q : act_coef_q;
    assign shift_c    = use_shadow ? shd_shift_q : act_shift_q;
    assign cfg_pending_o = pending_q;

    // Kernel shadow/active registers, frame tracking and the shift that travels with each beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_coef_q  <= IDENT;
            shd_coef_q  <= IDENT;
            act_shift_q <= '0;
            shd_shift_q <= '0;
            pending_q   <= 1'b0;
            in_frame_q  <= 1'b0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            sh3_q       <= '0;
        end else begin
            if (fs_beat && fe_beat) in_frame_q <= 1'b0;
            else if (fs_beat)       in_frame_q <= 1'b1;
            else if (fe_beat)       in_frame_q <= 1'b0;

            if (promote) begin
                act_coef_q  <= shd_coef_q;
                act_shift_q <= shd_shift_q;
            end

            if (cfg_wr_i) begin
                shd_coef_q  <= coef_i;
                shd_shift_q <= norm_shift_i;
                pending_q   <= 1'b1;
            end else if (promote) begin
                pending_q   <= 1'b0;
            end

            sh1_q <= shift_c;
            sh2_q <= sh1_q;
            sh3_q <= sh2_q;
        end
    end

    assign round_c = (sh2_q == '0) ? '0 : (TW'(1) << SHIFT_WIDTH'(sh2_q - SHIFT_WIDTH'(1)));

    for (genvar l = 0; l < PX_PER_CLK; l++) begin : g_lane
        logic signed [PW-1:0]  prod_c [NTAP];
        logic signed [PW-1:0]  prod_q [NTAP];
        logic signed [SW-1:0]  row_c  [WIN_SIZE];
        logic signed [SW-1:0]  row_q  [WIN_SIZE];
        logic signed [TW-1:0]  total_c, total_q, shifted_c;
        logic [PX_WIDTH-1:0]   sat_c, px_q;

        // Invalid lanes carry zero products so they settle to 0 after rounding and shift.
        always_comb begin
            for (int k = 0; k < int'(NTAP); k++) begin
                prod_c[k] = $signed(PW'({1'b0, bus.win_data_i[(l*NTAP + k)*PX_WIDTH +: PX_WIDTH]}))
                          * PW'($signed(kern_c[k*COEF_WIDTH +: COEF_WIDTH]));
            end
        end

        always_comb begin
            for (int r = 0; r < int'(WIN_SIZE); r++) begin
                row_c[r] = '0;
                for (int c = 0; c < int'(WIN_SIZE); c++) begin
                    row_c[r] = row_c[r] + SW'(prod_q[r*int'(WIN_SIZE) + c]);
                end
            end
        end

        always_comb begin
            total_c = round_c;
            for (int r = 0; r < int'(WIN_SIZE); r++) total_c = total_c + TW'(row_q[r]);
        end

        always_comb begin
            shifted_c = total_q >>> sh3_q;
            sat_c     = shifted_c[PX_WIDTH-1:0];
            if (shifted_c[TW-1])                  sat_c = '0;
            else if (|shifted_c[TW-2:PX_WIDTH])   sat_c = '1;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int k = 0; k < int'(NTAP); k++)     prod_q[k] <= '0;
                for (int r = 0; r < int'(WIN_SIZE); r++) row_q[r]  <= '0;
                total_q <= '0;
                px_q    <= '0;
            end else begin
                for (int k = 0; k < int'(NTAP); k++)
                    prod_q[k] <= bus.win_data_val_i[l] ? prod_c[k] : '0;
                for (int r = 0; r < int'(WIN_SIZE); r++) row_q[r] <= row_c[r];
                total_q <= total_c;
                px_q    <= sat_c;
            end
        end

        assign bus.px_data_o[l*PX_WIDTH +: PX_WIDTH] = px_q;
    end

    sideband_t        sb_in, sb_out;
    logic [DW-1:0]    dly_d, dly_q;

    assign sb_in.frame_start = bus.frame_start_i;
    assign sb_in.frame_end   = bus.frame_end_i;
    assign sb_in.line_start  = bus.line_start_i;
    assign sb_in.line_end    = bus.line_end_i;
    assign dly_d             = {sb_in, bus.win_data_val_i};

    stream_delay #(
        .WIDTH (DW),
        .DEPTH (LATENCY)
    ) u_stream_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (dly_d),
        .q_o   (dly_q)
    );

    assign sb_out            = dly_q[DW-1:PX_PER_CLK];
    assign bus.px_data_val_o = dly_q[PX_PER_CLK-1:0];
    assign bus.frame_start_o = sb_out.frame_start;
    assign bus.frame_end_o   = sb_out.frame_end;
    assign bus.line_start_o  = sb_out.line_start;
    assign bus.line_end_o    = sb_out.line_end;

endmodule

// File: tb/tb_window_conv.sv
// Directed and randomized checks of window_conv against an arithmetic reference model.
module tb_window_conv;
    import window_conv_pkg::*;

    localparam int unsigned PXW   = 12;
    localparam int unsigned LANES = 4;
    localparam int unsigned WIN   = 3;
    localparam int unsigned CW    = 8;
    localparam int unsigned NT    = WIN * WIN;
    localparam int unsigned DBITS = LANES * PXW;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [NT*CW-1:0] coef_i;
    logic [3:0]       norm_shift_i;
    logic             cfg_wr_i;
    logic             cfg_pending_o;

    always #5 clk_i = ~clk_i;

    window_conv_if #(.PX_WIDTH(PXW), .PX_PER_CLK(LANES), .WIN_SIZE(WIN)) bus ();

    window_conv #(
        .PX_WIDTH(PXW), .PX_PER_CLK(LANES), .WIN_SIZE(WIN), .COEF_WIDTH(CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .coef_i       (coef_i),
        .norm_shift_i (norm_shift_i),
        .cfg_wr_i     (cfg_wr_i),
        .cfg_pending_o(cfg_pending_o)
    );

    typedef struct packed {
        logic [DBITS-1:0] data;
        logic [3:0]       val;
        logic [3:0]       sb;
    } exp_t;

    // Stimulus state
    int         px [LANES][NT];
    logic [3:0] val;
    logic       fs, fe, ls, le;
    int         new_k [NT];
    int         new_sh;
    logic       wr;

    // Reference model state
    int   act_k [NT];
    int   shd_k [NT];
    int   act_sh, shd_sh;
    bit   pend, infr;
    exp_t pipe [4];

    int errors = 0;
    int checks = 0;
    logic [DBITS-1:0] exp_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NT); i++) begin
            act_k[i] = (i == int'(NT / 2)) ? 1 : 0;
            shd_k[i] = act_k[i];
        end
        act_sh = 0;
        shd_sh = 0;
        pend   = 1'b0;
        infr   = 1'b0;
        for (int i = 0; i < 4; i++) pipe[i] = '0;
    endtask

    task automatic drive();
        for (int l = 0; l < int'(LANES); l++)
            for (int i = 0; i < int'(NT); i++)
                bus.win_data_i[(l*int'(NT) + i)*int'(PXW) +: PXW] = PXW'(px[l][i]);
        for (int i = 0; i < int'(NT); i++) coef_i[i*int'(CW) +: CW] = CW'(new_k[i]);
        norm_shift_i       = 4'(new_sh);
        cfg_wr_i           = wr;
        bus.win_data_val_i = val;
        bus.frame_start_i  = fs;
        bus.frame_end_i    = fe;
        bus.line_start_i   = ls;
        bus.line_end_i     = le;
    endtask

    // One clock: apply inputs, advance the model, then compare outputs after the edge.
    task automatic tick();
        exp_t   e;
        int     k [NT];
        int     sh;
        bit     fsb, feb, use_s, prom;
        longint s;
        drive();
        if (rst_i) begin
            model_reset();
        end else begin
            fsb   = fs && (val != 4'b0);
            feb   = fe && (val != 4'b0);
            use_s = pend && fsb;
            for (int i = 0; i < int'(NT); i++) k[i] = use_s ? shd_k[i] : act_k[i];
            sh = use_s ? shd_sh : act_sh;
            e.data = '0;
            for (int l = 0; l < int'(LANES); l++) begin
                if (val[l]) begin
                    s = 0;
                    for (int i = 0; i < int'(NT); i++) s += longint'(px[l][i]) * longint'(k[i]);
                    if (sh > 0) s += longint'(1) << (sh - 1);
                    s = s >>> sh;
                    if (s < 0) s = 0;
                    if (s > 4095) s = 4095;
                    e.data[l*int'(PXW) +: PXW] = PXW'(s);
                end
            end
            e.val = val;
            e.sb  = {fs, fe, ls, le};
            prom  = pend && (fsb || !infr);
            if (fsb && feb) infr = 1'b0;
            else if (fsb)   infr = 1'b1;
            else if (feb)   infr = 1'b0;
            if (prom) begin
                for (int i = 0; i < int'(NT); i++) act_k[i] = shd_k[i];
                act_sh = shd_sh;
            end
            if (wr) begin
                for (int i = 0; i < int'(NT); i++) shd_k[i] = new_k[i];
                shd_sh = new_sh;
                pend   = 1'b1;
            end else if (prom) begin
                pend = 1'b0;
            end
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e;
        end
        @(posedge clk_i);
        #1;
        wr = 1'b0;
        chk("px_data", 64'(bus.px_data_o), 64'(pipe[3].data));
        chk("px_val", 64'(bus.px_data_val_o), 64'(pipe[3].val));
        chk("sideband", 64'({bus.frame_start_o, bus.frame_end_o, bus.line_start_o, bus.line_end_o}),
            64'(pipe[3].sb));
        chk("cfg_pending", 64'(cfg_pending_o), 64'(pend));
    endtask

    task automatic set_beat(input logic [3:0] v, input logic f_s, input logic f_e,
                            input logic l_s, input logic l_e);
        val = v; fs = f_s; fe = f_e; ls = l_s; le = l_e;
    endtask

    task automatic fill_px(input int centre, input int other);
        for (int l = 0; l < int'(LANES); l++)
            for (int i = 0; i < int'(NT); i++)
                px[l][i] = (i == int'(NT / 2)) ? centre : other;
    endtask

    task automatic rand_px();
        for (int l = 0; l < int'(LANES); l++)
            for (int i = 0; i < int'(NT); i++)
                px[l][i] = int'($urandom_range(0, 4095));
    endtask

    task automatic set_kernel(input int centre, input int other, input int sh);
        for (int i = 0; i < int'(NT); i++) new_k[i] = (i == int'(NT / 2)) ? centre : other;
        new_sh = sh;
        wr     = 1'b1;
    endtask

    task automatic idle(input int n);
        set_beat(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_i = 1'b1;
        wr    = 1'b0;
        new_sh = 0;
        for (int i = 0; i < int'(NT); i++) new_k[i] = 0;
        fill_px(0, 0);
        set_beat(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        drive();

        // Reset defaults
        repeat (3) tick();
        rst_i = 1'b0;
        idle(2);

        // Identity kernel, centre 1234, surrounding pixels irrelevant
        rand_px();
        for (int l = 0; l < int'(LANES); l++) px[l][NT/2] = 1234;
        set_beat(4'hf, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle(2);
        chk("lat3_val", 64'(bus.px_data_val_o), 64'(0));
        tick();
        exp_c = {4{12'd1234}};
        chk("centre_1234", 64'(bus.px_data_o), 64'(exp_c));
        chk("fs_aligned", 64'(bus.frame_start_o), 64'(1));
        chk("ls_aligned", 64'(bus.line_start_o), 64'(1));
        rand_px();
        set_beat(4'hf, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        idle(4);

        // Box filter, shift 3, flat 100 -> 113
        set_kernel(1, 1, 3);
        idle(1);
        chk("pend_set", 64'(cfg_pending_o), 64'(1));
        idle(1);
        chk("pend_clr_idle", 64'(cfg_pending_o), 64'(0));
        fill_px(100, 100);
        set_beat(4'hf, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle(3);
        exp_c = {4{12'd113}};
        chk("box_113", 64'(bus.px_data_o), 64'(exp_c));

        // Box filter, shift 0, full-scale pixels saturate
        set_kernel(1, 1, 0);
        idle(2);
        fill_px(4095, 4095);
        set_beat(4'hf, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle(3);
        exp_c = {4{12'd4095}};
        chk("sat_4095", 64'(bus.px_data_o), 64'(exp_c));

        // Laplacian on a bright centre clamps to 0
        set_kernel(-8, 1, 0);
        idle(2);
        fill_px(4000, 10);
        set_beat(4'hf, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle(3);
        chk("lap_zero", 64'(bus.px_data_o), 64'(0));
        chk("lap_val", 64'(bus.px_data_val_o), 64'(4'hf));

        // Kernel write mid-frame holds until the next frame start
        set_kernel(1, 0, 0);
        idle(2);
        rand_px();
        set_beat(4'hf, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        rand_px();
        set_beat(4'hf, 1'b0, 1'b0, 1'b0, 1'b0);
        set_kernel(1, 1, 3);
        tick();
        chk("mid_pend", 64'(cfg_pending_o), 64'(1));
        fill_px(2000, 50);
        tick();
        idle(3);
        exp_c = {4{12'd2000}};
        chk("old_kernel", 64'(bus.px_data_o), 64'(exp_c));
        chk("mid_pend_hold", 64'(cfg_pending_o), 64'(1));
        rand_px();
        set_beat(4'hf, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        fill_px(2000, 50);
        set_beat(4'hf, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("pend_clr_fs", 64'(cfg_pending_o), 64'(0));
        idle(3);
        exp_c = {4{12'd300}};
        chk("new_kernel", 64'(bus.px_data_o), 64'(exp_c));
        set_beat(4'hf, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();

        // Kernel write on the frame-start beat waits for the following frame
        fill_px(2000, 50);
        set_beat(4'hf, 1'b1, 1'b0, 1'b1, 1'b0);
        set_kernel(1, 0, 0);
        tick();
        idle(3);
        chk("wr_on_fs_old", 64'(bus.px_data_o), 64'(exp_c));
        set_beat(4'hf, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        idle(1);
        set_beat(4'hf, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle(4);

        // Alternating lane valids
        rand_px();
        set_beat(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(3);
        chk("val_0101", 64'(bus.px_data_val_o), 64'(4'b0101));
        chk("lane1_zero", 64'(bus.px_data_o[23:12]), 64'(0));
        chk("lane3_zero", 64'(bus.px_data_o[47:36]), 64'(0));

        // Randomized traffic with occasional kernel rewrites
        for (int n = 0; n < 400; n++) begin
            rand_px();
            set_beat(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                     1'($urandom), 1'($urandom));
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < int'(NT); i++) new_k[i] = int'($urandom_range(0, 255)) - 128;
                new_sh = int'($urandom_range(0, 15));
                wr     = 1'b1;
            end
            tick();
        end
        idle(4);

        // Reset pulse mid-line discards in-flight beats
        rand_px();
        set_beat(4'hf, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        rand_px();
        set_beat(4'hf, 1'b0, 1'b0, 1'b0, 1'b0);
        set_kernel(3, 1, 2);
        tick();
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_data", 64'(bus.px_data_o), 64'(0));
        chk("rst_val", 64'(bus.px_data_val_o), 64'(0));
        chk("rst_sb", 64'({bus.frame_start_o, bus.frame_end_o, bus.line_start_o, bus.line_end_o}),
            64'(0));
        chk("rst_pend", 64'(cfg_pending_o), 64'(0));
        model_reset();
        tick();
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            chk("post_rst_val", 64'(bus.px_data_val_o), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
